relatorio_medidas_n: RTL and testbench

- Parametrised multi-channel measurement reporter for the sensor datapath.
- Snapshots N_CANAIS BCD distance measurements and formats them as 7-bit ASCII digit/separator characters.
- Streams the characters one at a time to an external tx_serial_7E1 using its partida/pronto handshake.
- Frames start on demand or periodically. Successor to the fixed 3-sensor mux/counter chain: adds channel and digit parametrisation, snapshot capture, an optional terminator and an internal periodic trigger.

---
 rtl/relatorio_medidas_n.sv | 128 ++++++++++++
 tb/tb_relatorio_medidas_n.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relatorio_medidas_n.sv
// Snapshots N_CANAIS BCD measurements and streams them as ASCII characters to a serial transmitter.
// First tx_partida 2 cycles after a request; each character waits for tx_pronto, next one starts 2 cycles later.
`timescale 1ns/1ps
module relatorio_medidas_n #(
    parameter int         N_CANAIS       = 3,
    parameter int         DIGITOS        = 3,
    parameter logic [6:0] SEPARADOR      = 7'h23,
    parameter bit         USA_TERMINADOR = 1'b1,
    parameter logic [6:0] TERMINADOR     = 7'h0A,
    parameter int         PERIODO        = 1_000_000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_CANAIS*DIGITOS*4-1:0]   medidas,
    input  logic                            iniciar,
    input  logic                            modo_periodico,
    input  logic                            tx_pronto,
    output logic                            tx_partida,
    output logic [6:0]                      tx_dado,
    output logic                            ocupado,
    output logic                            fim,
    output logic [2:0]                      db_estado
);
    localparam int L  = N_CANAIS * (DIGITOS + 1) + (USA_TERMINADOR ? 1 : 0);
    localparam int KW = $clog2(L);
    localparam int CW = $clog2(PERIODO);
    localparam logic [KW-1:0] ULTIMO = KW'(L - 1);
    localparam logic [CW-1:0] TOPO   = CW'(PERIODO - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CAPTURA = 3'd1,
        ENVIA   = 3'd2,
        ESPERA  = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t                          estado, estado_prox;
    logic [N_CANAIS*DIGITOS*4-1:0]    snapshot;
    logic [KW-1:0]                    indice;
    logic [CW-1:0]                    contador;
    logic                             pendente;
    logic                             volta;
    logic [6:0]                       quadro [L];

    assign volta = modo_periodico && (contador == TOPO);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            snapshot <= '0;
            indice   <= '0;
            contador <= '0;
            pendente <= 1'b0;
        end else begin
            estado <= estado_prox;

            if (!modo_periodico || volta)
                contador <= '0;
            else
                contador <= contador + 1'b1;

            if (estado == CAPTURA) begin
                snapshot <= medidas;
                indice   <= '0;
            end else if (estado == PROXIMO && indice != ULTIMO) begin
                indice <= indice + 1'b1;
            end

            // A wrap landing in CAPTURA is a fresh request, so setting wins over clearing.
            if (volta)
                pendente <= 1'b1;
            else if (estado == CAPTURA)
                pendente <= 1'b0;
        end
    end

    // Character table for the whole frame; the slot left over after the channels holds the terminator.
    always_comb begin
        for (int i = 0; i < L; i++)
            quadro[i] = TERMINADOR;
        for (int c = 0; c < N_CANAIS; c++) begin
            for (int d = 0; d < DIGITOS; d++)
                quadro[c*(DIGITOS+1) + d] = {3'b011, snapshot[((c+1)*DIGITOS - 1 - d)*4 +: 4]};
            quadro[c*(DIGITOS+1) + DIGITOS] = SEPARADOR;
        end
    end

    always_comb begin
        estado_prox = estado;
        tx_partida  = 1'b0;
        tx_dado     = 7'd0;
        ocupado     = 1'b1;
        fim         = 1'b0;
        db_estado   = estado;
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (iniciar || pendente)
                    estado_prox = CAPTURA;
            end
            CAPTURA: estado_prox = ENVIA;
            ENVIA: begin
                tx_partida  = 1'b1;
                tx_dado     = quadro[indice];
                estado_prox = ESPERA;
            end
            ESPERA: begin
                tx_dado = quadro[indice];
                if (tx_pronto)
                    estado_prox = PROXIMO;
            end
            PROXIMO: begin
                tx_dado     = quadro[indice];
                estado_prox = (indice == ULTIMO) ? FIM : ENVIA;
            end
            FIM: begin
                fim         = 1'b1;
                estado_prox = OCIOSO;
            end
            default: begin
                ocupado     = 1'b0;
                estado_prox = OCIOSO;
            end
        endcase
    end
endmodule

// File: tb/tb_relatorio_medidas_n.sv
// Bench for relatorio_medidas_n: a default-parameter instance and a 1-channel/4-digit instance without terminator.
`timescale 1ns/1ps
module tb_relatorio_medidas_n;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic reset;

    logic [35:0] medidas_a;
    logic        iniciar_a, modo_a, pronto_auto_a, pronto_man_a;
    logic        partida_a, ocupado_a, fim_a;
    logic [6:0]  dado_a;
    logic [2:0]  estado_a;
    int          tx_delay_a = 5;
    bit          tx_auto_a  = 1'b1;
    int          part_cyc_a[$];
    logic [6:0]  part_dado_a[$];
    int          fim_cyc_a[$];
    int          pronto_cyc_a[$];
    logic [6:0]  exp_a[$];

    logic [15:0] medidas_b;
    logic        iniciar_b, modo_b, pronto_b;
    logic        partida_b, ocupado_b, fim_b;
    logic [6:0]  dado_b;
    logic [2:0]  estado_b;
    int          part_cyc_b[$];
    logic [6:0]  part_dado_b[$];
    int          fim_cyc_b[$];
    int          pronto_cyc_b[$];
    logic [6:0]  exp_b[$];

    relatorio_medidas_n #(.PERIODO(50)) dut_a (
        .clock(clock), .reset(reset), .medidas(medidas_a), .iniciar(iniciar_a),
        .modo_periodico(modo_a), .tx_pronto(pronto_auto_a | pronto_man_a),
        .tx_partida(partida_a), .tx_dado(dado_a), .ocupado(ocupado_a),
        .fim(fim_a), .db_estado(estado_a)
    );

    relatorio_medidas_n #(.N_CANAIS(1), .DIGITOS(4), .USA_TERMINADOR(1'b0), .PERIODO(50)) dut_b (
        .clock(clock), .reset(reset), .medidas(medidas_b), .iniciar(iniciar_b),
        .modo_periodico(modo_b), .tx_pronto(pronto_b),
        .tx_partida(partida_b), .tx_dado(dado_b), .ocupado(ocupado_b),
        .fim(fim_b), .db_estado(estado_b)
    );

    // Transmitter models: pronto pulse tx_delay cycles after the partida cycle.
    initial begin
        pronto_auto_a = 1'b0;
        forever begin
            @(negedge clock);
            if (partida_a && tx_auto_a) begin
                repeat (tx_delay_a) @(negedge clock);
                pronto_auto_a = 1'b1;
                pronto_cyc_a.push_back(cyc);
                @(negedge clock);
                pronto_auto_a = 1'b0;
            end
        end
    end

    initial begin
        pronto_b = 1'b0;
        forever begin
            @(negedge clock);
            if (partida_b) begin
                repeat (5) @(negedge clock);
                pronto_b = 1'b1;
                pronto_cyc_b.push_back(cyc);
                @(negedge clock);
                pronto_b = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (partida_a) begin part_cyc_a.push_back(cyc); part_dado_a.push_back(dado_a); end
        if (fim_a) fim_cyc_a.push_back(cyc);
        if (partida_b) begin part_cyc_b.push_back(cyc); part_dado_b.push_back(dado_b); end
        if (fim_b) fim_cyc_b.push_back(cyc);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_a();
        part_cyc_a.delete(); part_dado_a.delete(); fim_cyc_a.delete();
        pronto_cyc_a.delete(); exp_a.delete();
    endtask

    task automatic push_exp_a(input logic [35:0] m);
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 3; d++)
                exp_a.push_back({3'b011, m[c*12 + (2-d)*4 +: 4]});
            exp_a.push_back(7'h23);
        end
        exp_a.push_back(7'h0A);
    endtask

    task automatic pulse_iniciar_a(output int c0);
        tick();
        c0 = cyc;
        iniciar_a = 1'b1;
        tick();
        iniciar_a = 1'b0;
    endtask

    task automatic wait_part_a(input int n, input int budget);
        int k = 0;
        while (part_cyc_a.size() < n && k < budget) begin tick(); k++; end
        n_checks++;
        if (part_cyc_a.size() < n) begin
            n_fail++;
            $display("FAIL wait_partida_a: got %0d characters, required %0d within %0d cycles", part_cyc_a.size(), n, budget);
        end
    endtask

    task automatic wait_fim_a(input int n, input int budget);
        int k = 0;
        while (fim_cyc_a.size() < n && k < budget) begin tick(); k++; end
        n_checks++;
        if (fim_cyc_a.size() < n) begin
            n_fail++;
            $display("FAIL wait_fim_a: got %0d fim pulses, required %0d within %0d cycles", fim_cyc_a.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({partida_a, dado_a, ocupado_a, fim_a, estado_a} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs %h, required 0", {partida_a, dado_a, ocupado_a, fim_a, estado_a});
        end
        n_checks++;
        if ({partida_b, dado_b, ocupado_b, fim_b, estado_b} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs %h, required 0", {partida_b, dado_b, ocupado_b, fim_b, estado_b});
        end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (estado_a !== 3'd0 || ocupado_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: estado %0d ocupado %b, required 0 0", estado_a, ocupado_a);
        end
    endtask

    task automatic test_basic();
        int c0;
        logic [6:0] e, g;
        clear_a();
        medidas_a = {12'h300, 12'h045, 12'h123};
        push_exp_a(medidas_a);
        pulse_iniciar_a(c0);
        wait_fim_a(1, 300);
        repeat (5) tick();
        n_checks++;
        if (part_cyc_a.size() != 13) begin
            n_fail++; $display("FAIL basic_count: %0d characters, required 13", part_cyc_a.size());
        end
        n_checks++;
        if (part_cyc_a.size() == 0 || part_cyc_a[0] != c0 + 2) begin
            n_fail++; $display("FAIL basic_latency: first partida cycle %0d, required %0d", part_cyc_a.size() ? part_cyc_a[0] : -1, c0 + 2);
        end
        for (int k = 1; k < 13 && k < part_cyc_a.size() && k <= pronto_cyc_a.size(); k++) begin
            n_checks++;
            if (part_cyc_a[k] != pronto_cyc_a[k-1] + 2) begin
                n_fail++; $display("FAIL basic_spacing[%0d]: partida at %0d, required %0d", k, part_cyc_a[k], pronto_cyc_a[k-1] + 2);
            end
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            n_checks++;
            if (part_dado_a.size() == 0) begin
                n_fail++; $display("FAIL basic_char: missing, required %h", e);
            end else begin
                g = part_dado_a.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL basic_char: got %h, required %h", g, e); end
            end
        end
        n_checks++;
        if (fim_cyc_a.size() != 1 || pronto_cyc_a.size() < 13 || fim_cyc_a[0] != pronto_cyc_a[12] + 2) begin
            n_fail++; $display("FAIL basic_fim: %0d fim pulses, first at %0d, required 1 at last pronto + 2", fim_cyc_a.size(), fim_cyc_a.size() ? fim_cyc_a[0] : -1);
        end
        n_checks++;
        if (ocupado_a !== 1'b0 || dado_a !== 7'd0) begin
            n_fail++; $display("FAIL basic_idle: ocupado %b dado %h, required 0 00", ocupado_a, dado_a);
        end
    endtask

    task automatic test_b_no_terminator();
        int c0, k;
        logic [6:0] e, g;
        medidas_b = 16'h9A07;
        for (int d = 0; d < 4; d++) exp_b.push_back({3'b011, medidas_b[(3-d)*4 +: 4]});
        exp_b.push_back(7'h23);
        tick();
        c0 = cyc;
        iniciar_b = 1'b1;
        tick();
        iniciar_b = 1'b0;
        k = 0;
        while (fim_cyc_b.size() < 1 && k < 200) begin tick(); k++; end
        repeat (5) tick();
        n_checks++;
        if (part_cyc_b.size() == 0 || part_cyc_b[0] != c0 + 2) begin
            n_fail++; $display("FAIL b_latency: first partida cycle %0d, required %0d", part_cyc_b.size() ? part_cyc_b[0] : -1, c0 + 2);
        end
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_checks++;
            if (part_dado_b.size() == 0) begin
                n_fail++; $display("FAIL b_char: missing, required %h", e);
            end else begin
                g = part_dado_b.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b_char: got %h, required %h", g, e); end
            end
        end
        n_checks++;
        if (part_dado_b.size() != 0) begin
            n_fail++; $display("FAIL b_extra: %0d extra characters, required 0", part_dado_b.size());
        end
        n_checks++;
        if (fim_cyc_b.size() != 1 || pronto_cyc_b.size() < 5 || fim_cyc_b[0] != pronto_cyc_b[4] + 2) begin
            n_fail++; $display("FAIL b_fim: %0d fim pulses, first at %0d, required 1 at 5th pronto + 2", fim_cyc_b.size(), fim_cyc_b.size() ? fim_cyc_b[0] : -1);
        end
    endtask

    task automatic test_snapshot_busy();
        int c0;
        logic [6:0] e, g;
        clear_a();
        medidas_a = {12'h300, 12'h045, 12'h123};
        push_exp_a(medidas_a);
        pulse_iniciar_a(c0);
        wait_part_a(2, 50);
        medidas_a = {3{12'hFFF}};
        iniciar_a = 1'b1;
        repeat (40) tick();
        iniciar_a = 1'b0;
        wait_fim_a(1, 300);
        repeat (30) tick();
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            n_checks++;
            if (part_dado_a.size() == 0) begin
                n_fail++; $display("FAIL snapshot_char: missing, required %h", e);
            end else begin
                g = part_dado_a.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL snapshot_char: got %h, required %h", g, e); end
            end
        end
        n_checks++;
        if (fim_cyc_a.size() != 1 || part_cyc_a.size() != 13) begin
            n_fail++; $display("FAIL snapshot_frames: %0d fim, %0d characters, required 1 and 13", fim_cyc_a.size(), part_cyc_a.size());
        end
        medidas_a = {12'h300, 12'h045, 12'h123};
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        clear_a();
        pulse_iniciar_a(c0);
        wait_part_a(7, 100);
        tick();
        tick();
        n_checks++;
        if (estado_a !== 3'd3) begin
            n_fail++; $display("FAIL reset_mid_state: estado %0d before reset, required 3", estado_a);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({partida_a, dado_a, ocupado_a, fim_a, estado_a} !== 13'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: %h, required 0", {partida_a, dado_a, ocupado_a, fim_a, estado_a});
        end
        reset = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (part_cyc_a.size() != 7 || estado_a !== 3'd0) begin
            n_fail++; $display("FAIL reset_mid_silent: %0d characters estado %0d, required 7 and 0", part_cyc_a.size(), estado_a);
        end
    endtask

    task automatic test_pronto_same_cycle();
        int c0, k;
        clear_a();
        tx_auto_a = 1'b0;
        pulse_iniciar_a(c0);
        k = 0;
        while (partida_a !== 1'b1 && k < 10) begin tick(); k++; end
        pronto_man_a = 1'b1;
        tick();
        pronto_man_a = 1'b0;
        n_checks++;
        if (estado_a !== 3'd3) begin
            n_fail++; $display("FAIL same_cycle_wait: estado %0d, required 3", estado_a);
        end
        tick();
        tick();
        n_checks++;
        if (estado_a !== 3'd3 || partida_a !== 1'b0 || dado_a !== 7'h31) begin
            n_fail++; $display("FAIL same_cycle_hold: estado %0d partida %b dado %h, required 3 0 31", estado_a, partida_a, dado_a);
        end
        pronto_man_a = 1'b1;
        tick();
        pronto_man_a = 1'b0;
        tx_auto_a = 1'b1;
        n_checks++;
        if (estado_a !== 3'd4) begin
            n_fail++; $display("FAIL same_cycle_proximo: estado %0d, required 4", estado_a);
        end
        tick();
        n_checks++;
        if (partida_a !== 1'b1 || dado_a !== 7'h32) begin
            n_fail++; $display("FAIL same_cycle_next: partida %b dado %h, required 1 32", partida_a, dado_a);
        end
        wait_fim_a(1, 300);
        repeat (10) tick();
        n_checks++;
        if (fim_cyc_a.size() != 1 || part_cyc_a.size() != 13) begin
            n_fail++; $display("FAIL same_cycle_frame: %0d fim, %0d characters, required 1 and 13", fim_cyc_a.size(), part_cyc_a.size());
        end
    endtask

    task automatic test_periodic();
        int m0;
        logic [6:0] e, g;
        clear_a();
        tx_delay_a = 10;
        push_exp_a(medidas_a);
        push_exp_a(medidas_a);
        tick();
        m0 = cyc;
        modo_a = 1'b1;
        wait_part_a(1, 100);
        n_checks++;
        if (part_cyc_a.size() == 0 || part_cyc_a[0] != m0 + 52) begin
            n_fail++; $display("FAIL periodic_first: partida at %0d, required %0d", part_cyc_a.size() ? part_cyc_a[0] : -1, m0 + 52);
        end
        wait_part_a(14, 600);
        modo_a = 1'b0;
        n_checks++;
        if (fim_cyc_a.size() < 1 || part_cyc_a.size() < 14 || part_cyc_a[13] != fim_cyc_a[0] + 3) begin
            n_fail++; $display("FAIL periodic_pendente: second frame partida at %0d, required fim + 3 = %0d",
                               part_cyc_a.size() > 13 ? part_cyc_a[13] : -1, fim_cyc_a.size() ? fim_cyc_a[0] + 3 : -1);
        end
        wait_fim_a(2, 400);
        repeat (80) tick();
        n_checks++;
        if (fim_cyc_a.size() != 2 || part_cyc_a.size() != 26 || ocupado_a !== 1'b0) begin
            n_fail++; $display("FAIL periodic_frames: %0d fim, %0d characters, ocupado %b, required 2 26 0", fim_cyc_a.size(), part_cyc_a.size(), ocupado_a);
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            n_checks++;
            if (part_dado_a.size() == 0) begin
                n_fail++; $display("FAIL periodic_char: missing, required %h", e);
            end else begin
                g = part_dado_a.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL periodic_char: got %h, required %h", g, e); end
            end
        end
        tx_delay_a = 5;
    endtask

    initial begin
        reset        = 1'b1;
        medidas_a    = '0;
        iniciar_a    = 1'b0;
        modo_a       = 1'b0;
        pronto_man_a = 1'b0;
        medidas_b    = '0;
        iniciar_b    = 1'b0;
        modo_b       = 1'b0;
        test_reset();
        test_basic();
        test_b_no_terminator();
        test_snapshot_busy();
        test_reset_mid_frame();
        test_pronto_same_cycle();
        test_periodic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
